banked_rmw_mem: RTL and testbench

- Parametrised successor to the attention-head banked word memory.
- Stores words of WORD_W bits in BANKS x ROWS rows, each row holding WORDS_PER_ROW words; every bank is one 1rw1r row-wide SRAM.
- Partial-row writes use a read-modify-write sequence on port 0, so neighbouring words in the row are preserved.
- Has one independent registered read port on port 1. Sits between the attention-head datapath and its K/V/score buffers.

---
 rtl/banked_rmw_mem_pkg.sv | 24 ++
 rtl/sram_1rw1r_bank.sv | 40 ++++
 rtl/banked_rmw_mem.sv | 197 +++++++++++++++++++
 tb/tb_banked_rmw_mem.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_rmw_mem_pkg.sv
// Shared types and field-width helpers for the banked read-modify-write memory.
package banked_rmw_mem_pkg;

  typedef logic [0:0] wr_state_t;
  localparam wr_state_t ST_IDLE  = 1'b0;
  localparam wr_state_t ST_MERGE = 1'b1;

  function automatic int bank_bits(input int banks);
    return $clog2(banks);
  endfunction

  function automatic int row_bits(input int rows);
    return $clog2(rows);
  endfunction

  function automatic int word_bits(input int words_per_row);
    return $clog2(words_per_row);
  endfunction

  function automatic int row_width(input int word_w, input int words_per_row);
    return word_w * words_per_row;
  endfunction

endpackage

// File: rtl/sram_1rw1r_bank.sv
// Behavioural row-wide 1rw1r SRAM, active-low chip select / write enable,
// one-cycle read latency on both ports; stands in for the hard macro.
module sram_1rw1r_bank #(
  parameter int ROW_W = 128,
  parameter int ROWS  = 256,
  localparam int AW   = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             csb0_i,
  input  logic             web0_i,
  input  logic [AW-1:0]    addr0_i,
  input  logic [ROW_W-1:0] din0_i,
  output logic [ROW_W-1:0] dout0_o,
  input  logic             csb1_i,
  input  logic [AW-1:0]    addr1_i,
  output logic [ROW_W-1:0] dout1_o
);

  logic [ROW_W-1:0] mem_q [ROWS];
  logic [ROW_W-1:0] dout0_q;
  logic [ROW_W-1:0] dout1_q;

  // Port 1 reads the pre-write row when both ports hit the same row in one cycle.
  always_ff @(posedge clk) begin
    if (!csb0_i) begin
      if (!web0_i) begin
        mem_q[addr0_i] <= din0_i;
      end else begin
        dout0_q <= mem_q[addr0_i];
      end
    end
    if (!csb1_i) begin
      dout1_q <= mem_q[addr1_i];
    end
  end

  assign dout0_o = dout0_q;
  assign dout1_o = dout1_q;

endmodule

// File: rtl/banked_rmw_mem.sv
// Banked word memory: partial-row writes via read-modify-write on port 0,
// independent 2-cycle read on port 1. Optional byte masking: MEM_BYTE_MASK_EN.
module banked_rmw_mem
  import banked_rmw_mem_pkg::*;
#(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_ROW = 4,
  parameter int ROWS          = 256,
  parameter int BANKS         = 4,
  localparam int ADDR_W = bank_bits(BANKS) + row_bits(ROWS) + word_bits(WORDS_PER_ROW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
`ifdef MEM_BYTE_MASK_EN
  input  logic [WORD_W/8-1:0] wr_mask,
`endif
  output logic              wr_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int BANK_W  = bank_bits(BANKS);
  localparam int ROW_AW  = row_bits(ROWS);
  localparam int WORD_AW = word_bits(WORDS_PER_ROW);
  localparam int ROW_W   = row_width(WORD_W, WORDS_PER_ROW);
`ifdef MEM_BYTE_MASK_EN
  localparam int MASK_W  = WORD_W / 8;
`endif

  wr_state_t            state_q, state_d;
  logic                 wr_ready_q, wr_done_q;
  logic [BANK_W-1:0]    wa_bank_q, wa_bank_d;
  logic [ROW_AW-1:0]    wa_row_q, wa_row_d;
  logic [WORD_AW-1:0]   wa_word_q, wa_word_d;
  logic [WORD_W-1:0]    wa_data_q, wa_data_d;
`ifdef MEM_BYTE_MASK_EN
  logic [MASK_W-1:0]    wa_mask_q, wa_mask_d;
  logic [WORD_W-1:0]    word_old_s;
`endif

  logic [BANK_W-1:0]    wr_bank_s, rd_bank_s, p0_bank_s;
  logic [ROW_AW-1:0]    wr_row_s, rd_row_s, p0_row_s;
  logic [WORD_AW-1:0]   wr_word_s, rd_word_s;
  logic                 p0_rd_s, p0_wr_s;
  logic [BANKS-1:0]     csb0_s, csb1_s;
  logic [ROW_W-1:0]     p0_dout_s [BANKS];
  logic [ROW_W-1:0]     p1_dout_s [BANKS];
  logic [ROW_W-1:0]     row_old_s, row_merged_s, rd_row_data_s;
  logic [WORD_W-1:0]    word_new_s, rd_word_data_s;

  logic                 rd_pend_q, rd_valid_q;
  logic [BANK_W-1:0]    rd_bank_q;
  logic [WORD_AW-1:0]   rd_word_q;
  logic [WORD_W-1:0]    rd_data_q;

  assign wr_bank_s = wr_addr[ADDR_W-1 -: BANK_W];
  assign wr_row_s  = wr_addr[WORD_AW +: ROW_AW];
  assign wr_word_s = wr_addr[WORD_AW-1:0];
  assign rd_bank_s = rd_addr[ADDR_W-1 -: BANK_W];
  assign rd_row_s  = rd_addr[WORD_AW +: ROW_AW];
  assign rd_word_s = rd_addr[WORD_AW-1:0];

  // Write FSM next state and request capture.
  always_comb begin
    state_d   = state_q;
    wa_bank_d = wa_bank_q;
    wa_row_d  = wa_row_q;
    wa_word_d = wa_word_q;
    wa_data_d = wa_data_q;
`ifdef MEM_BYTE_MASK_EN
    wa_mask_d = wa_mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          state_d   = ST_MERGE;
          wa_bank_d = wr_bank_s;
          wa_row_d  = wr_row_s;
          wa_word_d = wr_word_s;
          wa_data_d = wr_data;
`ifdef MEM_BYTE_MASK_EN
          wa_mask_d = wr_mask;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MERGE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write FSM state, captured request and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ready_q <= 1'b1;
      wr_done_q  <= 1'b0;
      wa_bank_q  <= '0;
      wa_row_q   <= '0;
      wa_word_q  <= '0;
      wa_data_q  <= '0;
`ifdef MEM_BYTE_MASK_EN
      wa_mask_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ready_q <= (state_d == ST_IDLE);
      wr_done_q  <= (state_q == ST_MERGE);
      wa_bank_q  <= wa_bank_d;
      wa_row_q   <= wa_row_d;
      wa_word_q  <= wa_word_d;
      wa_data_q  <= wa_data_d;
`ifdef MEM_BYTE_MASK_EN
      wa_mask_q  <= wa_mask_d;
`endif
    end
  end

  // Reset gates the chip selects so an in-progress commit is dropped immediately.
  assign p0_rd_s   = (state_q == ST_IDLE) && wr_valid && !rst;
  assign p0_wr_s   = (state_q == ST_MERGE) && !rst;
  assign p0_bank_s = (state_q == ST_MERGE) ? wa_bank_q : wr_bank_s;
  assign p0_row_s  = (state_q == ST_MERGE) ? wa_row_q : wr_row_s;

  // Row merge: only the addressed word (and, when masked, its enabled bytes) changes.
  always_comb begin
    row_old_s  = p0_dout_s[wa_bank_q];
`ifdef MEM_BYTE_MASK_EN
    word_old_s = row_old_s[int'(wa_word_q)*WORD_W +: WORD_W];
    word_new_s = word_old_s;
    for (int k = 0; k < MASK_W; k++) begin
      word_new_s[k*8 +: 8] = wa_mask_q[k] ? wa_data_q[k*8 +: 8] : word_old_s[k*8 +: 8];
    end
`else
    word_new_s = wa_data_q;
`endif
    row_merged_s = row_old_s;
    row_merged_s[int'(wa_word_q)*WORD_W +: WORD_W] = word_new_s;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign csb0_s[b] = !((p0_rd_s || p0_wr_s) && (p0_bank_s == BANK_W'(b)));
    assign csb1_s[b] = !(rd_en && !rst && (rd_bank_s == BANK_W'(b)));

    sram_1rw1r_bank #(
      .ROW_W (ROW_W),
      .ROWS  (ROWS)
    ) u_sram (
      .clk     (clk),
      .csb0_i  (csb0_s[b]),
      .web0_i  (!p0_wr_s),
      .addr0_i (p0_row_s),
      .din0_i  (row_merged_s),
      .dout0_o (p0_dout_s[b]),
      .csb1_i  (csb1_s[b]),
      .addr1_i (rd_row_s),
      .dout1_o (p1_dout_s[b])
    );
  end

  assign rd_row_data_s  = p1_dout_s[rd_bank_q];
  assign rd_word_data_s = rd_row_data_s[int'(rd_word_q)*WORD_W +: WORD_W];

  // Read pipeline: SRAM access, then word select into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_bank_q  <= '0;
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend_q  <= rd_en;
      if (rd_en) begin
        rd_bank_q <= rd_bank_s;
        rd_word_q <= rd_word_s;
      end
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= rd_word_data_s;
      end
    end
  end

  assign wr_ready = wr_ready_q;
  assign wr_done  = wr_done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_banked_rmw_mem.sv
// Self-checking bench for banked_rmw_mem: word-level reference model, per-cycle
// compare, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_banked_rmw_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_addr = 12'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_mask = 4'hF;
  logic        wr_done;
  logic        rd_en = 1'b0;
  logic [11:0] rd_addr = 12'd0;
  logic [31:0] rd_data;
  logic        rd_valid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  banked_rmw_mem dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`ifdef MEM_BYTE_MASK_EN
    .wr_mask  (wr_mask),
`endif
    .wr_done  (wr_done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word granular) ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mem_m [4096];
  rd_t         rq[$];
  int          cyc = 0;
  bit          m_busy = 1'b0;
  logic [11:0] m_waddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic        m_ready = 1'b1;
  logic        m_done = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = m[k] ? new_w[k*8 +: 8] : old_w[k*8 +: 8];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_ready = 1'b1; m_done = 1'b0;
        m_rvalid = 1'b0; m_rdata = 32'd0;
        rq.delete();
      end else begin
        // reads of this cycle see the memory before any commit at this edge
        if (rd_en) rq.push_back('{due: cyc + 2, data: mem_m[rd_addr]});
        m_done = 1'b0;
        if (m_busy) begin
          mem_m[m_waddr] = byte_merge(mem_m[m_waddr], m_wdata, m_wmask);
          m_done = 1'b1;
          m_busy = 1'b0;
        end else if (wr_valid) begin
          m_busy  = 1'b1;
          m_waddr = wr_addr;
          m_wdata = wr_data;
`ifdef MEM_BYTE_MASK_EN
          m_wmask = wr_mask;
`else
          m_wmask = 4'hF;
`endif
        end
        m_ready = !m_busy;
      end
      cyc++;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        m_rvalid = 1'b1;
        m_rdata  = rq[0].data;
        void'(rq.pop_front());
      end else begin
        m_rvalid = 1'b0;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_ready});
      chk("wr_done",  {31'd0, wr_done},  {31'd0, m_done});
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rvalid});
      chk("rd_data",  rd_data, m_rdata);
    end
  end

  // ---------------- stimulus helpers (entered at negedge+1) ----------------
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] m, input bit pin);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    if (pin) begin
      chk("wr_ready_merge", {31'd0, wr_ready}, 32'd0);
      chk("wr_done_merge",  {31'd0, wr_done},  32'd0);
    end
    #1 wr_valid = 1'b0;
    @(negedge clk);
    if (pin) begin
      chk("wr_ready_back", {31'd0, wr_ready}, 32'd1);
      chk("wr_done_pulse", {31'd0, wr_done},  32'd1);
    end
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] lit, input string nm);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    chk({nm, "_early"}, {31'd0, rd_valid}, 32'd0);
    #1 rd_en = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(nm, rd_data, lit);
    #1;
  endtask

  function automatic logic [11:0] rnd_addr();
    return {2'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
  endfunction

  logic        vq [10];
  logic [31:0] dq [10];

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("reset_rd_data",  rd_data, 32'd0);
    #1 rst = 1'b0;

    for (int a = 0; a < 4096; a++) wr(12'(a), $urandom, 4'hF, 1'b0);

    wr(12'h005, 32'hDEADBEEF, 4'hF, 1'b1);
    chk("model_005", mem_m[12'h005], 32'hDEADBEEF);
    rd(12'h005, 32'hDEADBEEF, "rd_005");

    wr(12'h010, 32'h11111111, 4'hF, 1'b0);
    wr(12'h011, 32'h22222222, 4'hF, 1'b0);
    wr(12'h012, 32'h33333333, 4'hF, 1'b0);
    wr(12'h013, 32'h44444444, 4'hF, 1'b0);
    rd(12'h010, 32'h11111111, "rd_010");
    rd(12'h011, 32'h22222222, "rd_011");
    rd(12'h012, 32'h33333333, "rd_012");
    rd(12'h013, 32'h44444444, "rd_013");

    wr(12'hC04, 32'hAAAA5555, 4'hF, 1'b0);
    wr(12'h404, 32'h12345678, 4'hF, 1'b0);
    rd(12'hC04, 32'hAAAA5555, "rd_C04");
    rd(12'h404, 32'h12345678, "rd_404");

    // same-row collision around a commit
    wr(12'h021, 32'h0BADF00D, 4'hF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rd_en    = (i < 8);
      rd_addr  = (i == 2 || i == 3) ? 12'h021 : 12'h020;
      wr_valid = (i == 1);
      wr_addr  = 12'h021; wr_data = 32'hCAFEF00D; wr_mask = 4'hF;
      @(negedge clk);
      vq[i] = rd_valid; dq[i] = rd_data;
      #1;
    end
    rd_en = 1'b0;
    for (int i = 0; i < 10; i++) chk("coll_valid", {31'd0, vq[i]}, {31'd0, (i >= 1 && i <= 8)});
    chk("coll_old", dq[3], 32'h0BADF00D);
    chk("coll_new", dq[4], 32'hCAFEF00D);

    // reset during MERGE aborts the commit
    wr(12'h030, 32'h00000000, 4'hF, 1'b0);
    wr_valid = 1'b1; wr_addr = 12'h030; wr_data = 32'hFFFFFFFF; wr_mask = 4'hF;
    @(negedge clk);
    chk("abort_merge_ready", {31'd0, wr_ready}, 32'd0);
    #1 wr_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_no_done",  {31'd0, wr_done},  32'd0);
    chk("abort_ready",    {31'd0, wr_ready}, 32'd1);
    chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("abort_rd_data",  rd_data, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    rd(12'h030, 32'h00000000, "rd_030_after_rst");

`ifdef MEM_BYTE_MASK_EN
    wr(12'h040, 32'h11223344, 4'hF, 1'b0);
    wr(12'h040, 32'hAABBCCDD, 4'b0101, 1'b1);
    chk("model_mask", mem_m[12'h040], 32'h11BB33DD);
    rd(12'h040, 32'h11BB33DD, "rd_mask");
    wr(12'h040, 32'h55555555, 4'b0000, 1'b1);
    rd(12'h040, 32'h11BB33DD, "rd_mask_zero");
`endif

    for (int c = 0; c < 3000; c++) begin
      rd_en    = 1'($urandom_range(0, 1));
      rd_addr  = rnd_addr();
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = rnd_addr();
      wr_data  = $urandom;
      wr_mask  = 4'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      @(negedge clk); #1;
    end
    rst = 1'b0; rd_en = 1'b0; wr_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
